// File: rtl/dmi_bus_arbiter.sv
// dmi_bus_arbiter: round-robin arbiter giving JTAG DMI and the APB window exclusive use of the debug module DMI port
module dmi_bus_arbiter #(
    parameter int abits = 7
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_jtag_req_valid,
    output logic             o_jtag_req_ready,
    input  logic             i_jtag_write,
    input  logic [abits-1:0] i_jtag_addr,
    input  logic [31:0]      i_jtag_wdata,
    output logic             o_jtag_resp_valid,
    input  logic             i_jtag_resp_ready,
    output logic [31:0]      o_jtag_resp_data,
    input  logic             i_apb_psel,
    input  logic             i_apb_penable,
    input  logic             i_apb_pwrite,
    input  logic [11:0]      i_apb_paddr,
    input  logic [31:0]      i_apb_pwdata,
    output logic [31:0]      o_apb_prdata,
    output logic             o_apb_pready,
    output logic             o_apb_pslverr,
    output logic             o_dmi_req_valid,
    input  logic             i_dmi_req_ready,
    output logic             o_dmi_write,
    output logic [abits-1:0] o_dmi_addr,
    output logic [31:0]      o_dmi_wdata,
    input  logic             i_dmi_resp_valid,
    output logic             o_dmi_resp_ready,
    input  logic [31:0]      i_dmi_resp_data,
    output logic             o_bus_jtag
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, JTAG_HOLD, APB_DONE} state_t;
    state_t state;
    logic prio;
    logic apb_pend, grant_j, grant_a, apb_err, unused_ok;
    assign apb_pend = i_apb_psel & i_apb_penable & (state == IDLE);
    assign grant_j = (state == IDLE) & i_jtag_req_valid & (~apb_pend | prio);
    assign grant_a = apb_pend & (~i_jtag_req_valid | ~prio);
    assign apb_err = |i_apb_paddr[11:abits+2];
    assign o_jtag_req_ready = grant_j;
    assign unused_ok = ^i_apb_paddr[1:0];
    // Arbitration FSM: grant in IDLE, forward request, collect response, return it to the owner
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
            prio <= 1'b1;
            o_bus_jtag <= 1'b0;
            o_dmi_req_valid <= 1'b0;
            o_dmi_resp_ready <= 1'b0;
            o_dmi_write <= 1'b0;
            o_dmi_addr <= '0;
            o_dmi_wdata <= '0;
            o_jtag_resp_valid <= 1'b0;
            o_jtag_resp_data <= '0;
            o_apb_pready <= 1'b0;
            o_apb_pslverr <= 1'b0;
            o_apb_prdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_j) begin
                        state <= REQ;
                        o_dmi_req_valid <= 1'b1;
                        o_dmi_write <= i_jtag_write;
                        o_dmi_addr <= i_jtag_addr;
                        o_dmi_wdata <= i_jtag_wdata;
                        o_bus_jtag <= 1'b1;
                        prio <= 1'b0;
                    end else if (grant_a && apb_err) begin
                        state <= APB_DONE;
                        o_apb_pready <= 1'b1;
                        o_apb_pslverr <= 1'b1;
                        o_apb_prdata <= '0;
                    end else if (grant_a) begin
                        state <= REQ;
                        o_dmi_req_valid <= 1'b1;
                        o_dmi_write <= i_apb_pwrite;
                        o_dmi_addr <= i_apb_paddr[abits+1:2];
                        o_dmi_wdata <= i_apb_pwdata;
                        o_bus_jtag <= 1'b0;
                        prio <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_dmi_req_ready) begin
                        state <= RESP;
                        o_dmi_req_valid <= 1'b0;
                        o_dmi_resp_ready <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_dmi_resp_valid) begin
                        o_dmi_resp_ready <= 1'b0;
                        if (o_bus_jtag) begin
                            state <= JTAG_HOLD;
                            o_jtag_resp_valid <= 1'b1;
                            o_jtag_resp_data <= i_dmi_resp_data;
                        end else begin
                            state <= APB_DONE;
                            o_apb_pready <= 1'b1;
                            o_apb_pslverr <= 1'b0;
                            o_apb_prdata <= i_dmi_resp_data;
                        end
                    end
                end
                JTAG_HOLD: begin
                    if (i_jtag_resp_ready) begin
                        state <= IDLE;
                        o_jtag_resp_valid <= 1'b0;
                    end
                end
                APB_DONE: begin
                    state <= IDLE;
                    o_apb_pready <= 1'b0;
                    o_apb_pslverr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_bus_arbiter.sv
// tb_dmi_bus_arbiter: scoreboard bench for dmi_bus_arbiter with a behavioural debug module
module tb_dmi_bus_arbiter;
    typedef struct packed {logic wr; logic [6:0] a; logic [31:0] d;} req_t;
    logic i_clk = 1'b0, i_nrst;
    logic i_jtag_req_valid, o_jtag_req_ready, i_jtag_write;
    logic [6:0] i_jtag_addr;
    logic [31:0] i_jtag_wdata, o_jtag_resp_data;
    logic o_jtag_resp_valid, i_jtag_resp_ready;
    logic i_apb_psel, i_apb_penable, i_apb_pwrite;
    logic [11:0] i_apb_paddr;
    logic [31:0] i_apb_pwdata, o_apb_prdata;
    logic o_apb_pready, o_apb_pslverr;
    logic o_dmi_req_valid, i_dmi_req_ready, o_dmi_write;
    logic [6:0] o_dmi_addr;
    logic [31:0] o_dmi_wdata, i_dmi_resp_data;
    logic i_dmi_resp_valid, o_dmi_resp_ready, o_bus_jtag;
    logic [110:0] all_outs;
    logic [31:0] jtag_q[$];
    logic [32:0] apb_q[$];
    bit own_q[$];
    req_t jf_q[$], af_q[$];
    logic [31:0] dm_mem[128], ref_mem[128];
    int n_cmp = 0, n_bad = 0, dm_delay = 0, dm_cnt = 0;
    logic dm_req_hs, dm_resp_hs, dm_w, mon_e;
    logic [6:0] dm_a;
    logic [31:0] dm_wd, exp_d;
    req_t mon_f;
    int lat, lat2, n;

    dmi_bus_arbiter #(.abits(7)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_jtag_req_valid(i_jtag_req_valid), .o_jtag_req_ready(o_jtag_req_ready),
        .i_jtag_write(i_jtag_write), .i_jtag_addr(i_jtag_addr), .i_jtag_wdata(i_jtag_wdata),
        .o_jtag_resp_valid(o_jtag_resp_valid), .i_jtag_resp_ready(i_jtag_resp_ready),
        .o_jtag_resp_data(o_jtag_resp_data),
        .i_apb_psel(i_apb_psel), .i_apb_penable(i_apb_penable), .i_apb_pwrite(i_apb_pwrite),
        .i_apb_paddr(i_apb_paddr), .i_apb_pwdata(i_apb_pwdata), .o_apb_prdata(o_apb_prdata),
        .o_apb_pready(o_apb_pready), .o_apb_pslverr(o_apb_pslverr),
        .o_dmi_req_valid(o_dmi_req_valid), .i_dmi_req_ready(i_dmi_req_ready),
        .o_dmi_write(o_dmi_write), .o_dmi_addr(o_dmi_addr), .o_dmi_wdata(o_dmi_wdata),
        .i_dmi_resp_valid(i_dmi_resp_valid), .o_dmi_resp_ready(o_dmi_resp_ready),
        .i_dmi_resp_data(i_dmi_resp_data), .o_bus_jtag(o_bus_jtag)
    );

    assign all_outs = {o_jtag_req_ready, o_jtag_resp_valid, o_jtag_resp_data, o_apb_prdata,
                       o_apb_pready, o_apb_pslverr, o_dmi_req_valid, o_dmi_write, o_dmi_addr,
                       o_dmi_wdata, o_dmi_resp_ready, o_bus_jtag};

    initial forever #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Debug module model: programmable request stall, one-cycle response, memory-backed registers
    initial forever begin
        @(negedge i_clk);
        if (!i_nrst) begin
            i_dmi_req_ready = 0;
            i_dmi_resp_valid = 0;
            dm_cnt = 0;
            dm_req_hs = 0;
            dm_resp_hs = 0;
        end else begin
            if (dm_resp_hs) i_dmi_resp_valid = 0;
            if (dm_req_hs) begin
                if (dm_w) dm_mem[dm_a] = dm_wd;
                i_dmi_resp_data = dm_w ? dm_wd : dm_mem[dm_a];
                i_dmi_resp_valid = 1;
            end
            i_dmi_req_ready = o_dmi_req_valid && dm_cnt >= dm_delay;
            dm_cnt = o_dmi_req_valid ? dm_cnt + 1 : 0;
            #2;
            dm_req_hs = o_dmi_req_valid & i_dmi_req_ready;
            dm_resp_hs = o_dmi_resp_ready & i_dmi_resp_valid;
            dm_a = o_dmi_addr;
            dm_w = o_dmi_write;
            dm_wd = o_dmi_wdata;
        end
    end

    // Scoreboard: compare each handshake against the expectation queued at stimulus time
    initial forever begin
        @(negedge i_clk);
        #2;
        if (i_nrst) begin
            if (o_dmi_req_valid && i_dmi_req_ready) begin
                check("dmi_expected", own_q.size() != 0, 1);
                if (own_q.size() != 0) begin
                    mon_e = own_q.pop_front();
                    check("dmi_owner", o_bus_jtag, mon_e);
                    if (mon_e && jf_q.size() != 0) mon_f = jf_q.pop_front();
                    else if (!mon_e && af_q.size() != 0) mon_f = af_q.pop_front();
                    check("dmi_fields", {o_dmi_write, o_dmi_addr, o_dmi_wdata}, mon_f);
                end
            end
            if (o_jtag_resp_valid && i_jtag_resp_ready) begin
                check("jtag_expected", jtag_q.size() != 0, 1);
                if (jtag_q.size() != 0) check("jtag_rdata", o_jtag_resp_data, jtag_q.pop_front());
            end
            if (o_apb_pready) begin
                check("apb_expected", apb_q.size() != 0, 1);
                if (apb_q.size() != 0) check("apb_resp", {o_apb_pslverr, o_apb_prdata}, apb_q.pop_front());
            end
        end
    end

    task automatic jtag_txn(input logic wr, input logic [6:0] a, input logic [31:0] d);
        jtag_q.push_back(wr ? d : ref_mem[a]);
        jf_q.push_back({wr, a, d});
        if (wr) ref_mem[a] = d;
        i_jtag_req_valid = 1;
        i_jtag_write = wr;
        i_jtag_addr = a;
        i_jtag_wdata = d;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (o_jtag_req_ready) break;
            @(negedge i_clk);
        end
        check("jtag_grant", o_jtag_req_ready, 1);
        @(negedge i_clk);
        i_jtag_req_valid = 0;
    endtask

    task automatic apb_txn(input logic wr, input logic [11:0] pa, input logic [31:0] d, output int l);
        logic err;
        logic [6:0] idx;
        err = |pa[11:9];
        idx = pa[8:2];
        apb_q.push_back(err ? {1'b1, 32'h0} : {1'b0, (wr ? d : ref_mem[idx])});
        if (!err) begin
            af_q.push_back({wr, idx, d});
            if (wr) ref_mem[idx] = d;
        end
        i_apb_psel = 1;
        i_apb_penable = 0;
        i_apb_pwrite = wr;
        i_apb_paddr = pa;
        i_apb_pwdata = d;
        @(negedge i_clk);
        i_apb_penable = 1;
        l = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            #1;
            l++;
            if (o_apb_pready) break;
        end
        check("apb_done", o_apb_pready, 1);
        @(negedge i_clk);
        i_apb_psel = 0;
        i_apb_penable = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (jtag_q.size() + apb_q.size() + own_q.size() + jf_q.size() + af_q.size() == 0) break;
            @(negedge i_clk);
        end
        repeat (2) @(negedge i_clk);
        check("drain", jtag_q.size() + apb_q.size() + own_q.size() + jf_q.size() + af_q.size(), 0);
    endtask

    initial begin
        i_nrst = 0;
        {i_jtag_req_valid, i_jtag_write, i_jtag_addr, i_jtag_wdata} = '0;
        {i_apb_psel, i_apb_penable, i_apb_pwrite, i_apb_paddr, i_apb_pwdata} = '0;
        {i_dmi_req_ready, i_dmi_resp_valid, i_dmi_resp_data} = '0;
        i_jtag_resp_ready = 1;
        for (int i = 0; i < 128; i++) begin
            dm_mem[i] = 32'hA5000000 + i * 32'h101;
            ref_mem[i] = 32'hA5000000 + i * 32'h101;
        end
        dm_mem[17] = 32'h382;
        ref_mem[17] = 32'h382;
        repeat (3) @(negedge i_clk);
        #1 check("reset_outputs", all_outs, 0);
        @(negedge i_clk);
        i_nrst = 1;
        @(negedge i_clk);
        own_q.push_back(1);
        jtag_txn(0, 7'h11, 32'h0);
        #1 check("t1_req_valid", o_dmi_req_valid, 1);
        @(negedge i_clk);
        #1 check("t2_resp_ready", o_dmi_resp_ready, 1);
        @(negedge i_clk);
        #1 check("t3_jtag_resp", {o_jtag_resp_valid, o_jtag_resp_data}, {1'b1, 32'h382});
        check("t3_bus_jtag", o_bus_jtag, 1);
        drain();
        dm_delay = 3;
        own_q.push_back(0);
        n = 0;
        fork
            apb_txn(1, 12'h040, 32'h1, lat);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge i_clk);
                    #1;
                    if (o_dmi_req_valid) break;
                end
                while (o_dmi_req_valid && n < 50) begin
                    n++;
                    @(negedge i_clk);
                    #1;
                end
            end
        join
        check("apb_req_hold", n, 4);
        check("apb_latency", lat, 6);
        check("apb_bus_owner", o_bus_jtag, 0);
        dm_delay = 0;
        drain();
        i_nrst = 0;
        @(negedge i_clk);
        i_nrst = 1;
        @(negedge i_clk);
        own_q.push_back(1);
        own_q.push_back(0);
        own_q.push_back(1);
        own_q.push_back(0);
        fork
            begin
                apb_txn(0, 12'h100, 32'h0, lat);
                apb_txn(0, 12'h104, 32'h0, lat2);
            end
            begin
                @(negedge i_clk);
                jtag_txn(0, 7'h20, 32'h0);
                jtag_txn(0, 7'h21, 32'h0);
            end
        join
        drain();
        apb_txn(0, 12'h800, 32'h0, lat);
        check("err_latency", lat, 1);
        drain();
        own_q.push_back(1);
        own_q.push_back(0);
        fork
            apb_txn(1, 12'h0C0, 32'hCAFE0001, lat);
            begin
                @(negedge i_clk);
                jtag_txn(1, 7'h31, 32'h5EED0002);
            end
        join
        drain();
        i_jtag_resp_ready = 0;
        exp_d = ref_mem[7'h22];
        own_q.push_back(1);
        own_q.push_back(0);
        fork
            jtag_txn(0, 7'h22, 32'h0);
            begin
                @(negedge i_clk);
                apb_txn(0, 12'h108, 32'h0, lat);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge i_clk);
                    #1;
                    if (o_jtag_resp_valid) break;
                end
                repeat (5) begin
                    check("hold_resp", {o_jtag_resp_valid, o_jtag_resp_data}, {1'b1, exp_d});
                    check("hold_no_grant", o_dmi_req_valid, 0);
                    @(negedge i_clk);
                    #1;
                end
                i_jtag_resp_ready = 1;
                @(negedge i_clk);
                #1 check("apb_not_yet", o_dmi_req_valid, 0);
                @(negedge i_clk);
                #1 check("apb_granted", {o_dmi_req_valid, o_bus_jtag}, 2'b10);
            end
        join
        drain();
        dm_delay = 10;
        own_q.push_back(1);
        jtag_txn(0, 7'h11, 32'h0);
        #3 i_nrst = 0;
        #1 check("async_reset", all_outs, 0);
        jtag_q.delete();
        apb_q.delete();
        own_q.delete();
        jf_q.delete();
        af_q.delete();
        repeat (2) @(negedge i_clk);
        i_nrst = 1;
        dm_delay = 0;
        @(negedge i_clk);
        own_q.push_back(1);
        jtag_txn(0, 7'h11, 32'h0);
        drain();
        check("post_reset_owner", o_bus_jtag, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmi_bus_arbiter.md
# dmi_bus_arbiter

Arbitrates between the JTAG DMI channel and the APB slave window for exclusive access to the single DMI register port of the debug module. It serializes accesses with round-robin fairness and holds the grant until the DMI response completes. It returns read data to the owning requester and drives the bus-owner flag the debug module uses to route responses. The block sits between the JTAG TAP/DTM, the APB interconnect and the debug module register file.

## Interface
- abits, 7, DMI register address width (word index)
- i_clk  in  1  system clock, all flops rising-edge
- i_nrst  in  1  reset, asynchronous, active-low
- i_jtag_req_valid  in  1  JTAG DMI request pending
- o_jtag_req_ready  out  1  JTAG request accepted this cycle
- i_jtag_write  in  1  1=write, 0=read
- i_jtag_addr  in  abits  DMI register index
- i_jtag_wdata  in  32  write data
- o_jtag_resp_valid  out  1  JTAG response valid
- i_jtag_resp_ready  in  1  JTAG consumes response
- o_jtag_resp_data  out  32  read data
- i_apb_psel, i_apb_penable, i_apb_pwrite  in  1 each  APB control
- i_apb_paddr  in  12  byte address; DMI index = paddr[abits+1:2]
- i_apb_pwdata  in  32  write data
- o_apb_prdata  out  32  read data
- o_apb_pready  out  1  APB completion
- o_apb_pslverr  out  1  APB error
- o_dmi_req_valid  out  1  request to debug module
- i_dmi_req_ready  in  1  debug module accepts request
- o_dmi_write  out  1  1=write
- o_dmi_addr  out  abits  register index
- o_dmi_wdata  out  32  write data
- i_dmi_resp_valid  in  1  response from debug module
- o_dmi_resp_ready  out  1  arbiter accepts response
- i_dmi_resp_data  in  32  read data
- o_bus_jtag  out  1  current/last owner: 1=JTAG, 0=APB

## Operation
- States: IDLE, REQ, RESP, JTAG_HOLD, APB_DONE.
- APB request is pending when psel & penable & state==IDLE.
- IDLE: if exactly one requester is pending, grant it. If both are pending, grant the one not equal to the last owner; `prio` resets to JTAG preferred.
- On grant: latch write, addr and wdata into registers; set o_bus_jtag; flip `prio`; go to REQ. A JTAG grant pulses o_jtag_req_ready for 1 cycle, combinationally in IDLE.
- APB address check: paddr[11:abits+2] != 0 bypasses DMI and goes to APB_DONE with pslverr=1 and prdata=0. No grant is consumed; prio is unchanged.
- REQ: o_dmi_req_valid=1 with the latched fields. Hold until i_dmi_req_ready, then go to RESP.
- RESP: o_dmi_resp_ready=1. On i_dmi_resp_valid, capture resp_data (write responses are also captured). Go to JTAG_HOLD if the owner is JTAG, otherwise APB_DONE.
- JTAG_HOLD: o_jtag_resp_valid=1 with the captured data. On i_jtag_resp_ready, go to IDLE.
- APB_DONE: o_apb_pready=1 for exactly 1 cycle, prdata = captured data, then IDLE.
- No new grant is issued outside IDLE; the other requester waits.
- o_bus_jtag keeps the last owner through IDLE.

## Timing
- Reset values: state=IDLE, prio=JTAG, o_bus_jtag=0, all valid/ready/pready/pslverr=0, all data/address outputs=0.
- All outputs are registered except o_jtag_req_ready, which is decoded from IDLE and the grant.
- Minimum JTAG latency (ready always 1): grant at T0, req_valid at T1, resp_ready at T2, resp_valid at T3. Next grant no earlier than T4.
- Minimum APB latency: penable seen at T0, pready at T3. An address error gives pready at T1.
- i_dmi_resp_valid seen in REQ is ignored. Responses are accepted only in RESP.
- An async reset mid-transaction returns to IDLE immediately and drops all valids. The debug module must tolerate an abandoned request.
- APB master deasserting psel before pready is a protocol violation and the behaviour is undefined. JTAG fields must be stable only in the grant cycle.

## Test plan
- Single JTAG read addr 0x11, DM returns 0x00000382 with zero wait -> req_ready at T0, dmi_req_valid T1, jtag_resp_valid T3 with data 0x00000382, o_bus_jtag=1.
- APB write paddr 0x040 (index 0x10), pwdata 0x00000001, DM req_ready delayed 3 cycles -> dmi_addr=0x10, dmi_write=1, req_valid held 4 cycles, pready one cycle later with pslverr=0, o_bus_jtag=0.
- Both pending continuously from reset, 4 transactions -> grant order JTAG, APB, JTAG, APB.
- APB paddr 0x800 -> pready at T1, pslverr=1, prdata=0, no dmi_req_valid, next simultaneous request still goes to JTAG.
- JTAG response with i_jtag_resp_ready low 5 cycles while APB pending -> resp_valid and data stable, APB not granted until the cycle after resp_ready.
- Assert i_nrst low during REQ -> all outputs return to reset values asynchronously; after release a JTAG request completes normally.
